// File: rtl/m_memarb_pkg.sv
// Shared types and defaults for the I/D memory arbiter.
package m_memarb_pkg;

    localparam int unsigned AW_DEF        = 12;
    localparam int unsigned DW_DEF        = 32;
    localparam int unsigned WAIT_DEF      = 0;
    localparam int unsigned MAXSTARVE_DEF = 4;
    localparam int unsigned CNT_W         = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAITS = 3'd2,
        ST_CAPT  = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

endpackage

// File: rtl/m_memarb_prio_starve.sv
// Two-way fixed-priority arbiter (D over I) with a saturating starvation counter
// that hands the contest to I after MAXSTARVE consecutive D wins while I waits.
module m_prio_starve
    import m_memarb_pkg::*;
#(
    parameter int unsigned MAXSTARVE = MAXSTARVE_DEF
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   i_req,
    input  logic   d_req,
    input  logic   advance,
    output owner_t winner,
    output logic   valid
);

    logic [CNT_W-1:0] starve_cnt;
    logic             force_i;

    always_comb begin
        force_i = i_req && (starve_cnt >= CNT_W'(MAXSTARVE));
        valid   = i_req || d_req;
        winner  = (d_req && !force_i) ? OWN_D : OWN_I;
    end

    // Counter only moves when a contest is actually decided.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (advance && valid) begin
            if (winner == OWN_I) begin
                starve_cnt <= '0;
            end else if (i_req && (starve_cnt < CNT_W'(MAXSTARVE))) begin
                starve_cnt <= starve_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/m_memarb.sv
// Shares one single-port registered-read memory between the fetch (I) and
// data (D) ports: one access in flight, optional wait states, pulsed gnt/rvalid.
module m_memarb
    import m_memarb_pkg::*;
#(
    parameter int unsigned AW        = AW_DEF,
    parameter int unsigned DW        = DW_DEF,
    parameter int unsigned WAIT      = WAIT_DEF,
    parameter int unsigned MAXSTARVE = MAXSTARVE_DEF
) (
    input  logic          w_clk,
    input  logic          w_rst,
    input  logic          w_i_req,
    input  logic [AW-1:0] w_i_addr,
    output logic          r_i_gnt,
    output logic          r_i_rvalid,
    input  logic          w_d_req,
    input  logic          w_d_we,
    input  logic [AW-1:0] w_d_addr,
    input  logic [DW-1:0] w_d_wdata,
    output logic          r_d_gnt,
    output logic          r_d_rvalid,
    output logic [DW-1:0] r_rdata,
    output logic [AW-1:0] r_mem_addr,
    output logic          r_mem_we,
    output logic [DW-1:0] r_mem_din,
    input  logic [DW-1:0] w_mem_dout,
    output logic          r_busy
);

    localparam int unsigned WCNT_W = 4;

    state_t              state;
    state_t              state_nx;
    logic [WCNT_W-1:0]   wait_cnt;
    logic [WCNT_W-1:0]   wait_nx;
    owner_t              owner;
    owner_t              winner;
    logic                arb_valid;
    logic                arb_slot;
    logic                capture;

    assign arb_slot = (state == ST_IDLE) || (state == ST_RESP);

    m_prio_starve #(
        .MAXSTARVE (MAXSTARVE)
    ) u_prio (
        .clk     (w_clk),
        .rst_n   (w_rst),
        .i_req   (w_i_req),
        .d_req   (w_d_req),
        .advance (arb_slot),
        .winner  (winner),
        .valid   (arb_valid)
    );

    // Next-state logic; RESP arbitrates like IDLE so accesses run back to back.
    always_comb begin
        state_nx = state;
        wait_nx  = wait_cnt;
        capture  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (arb_valid) begin
                    capture  = 1'b1;
                    state_nx = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (WAIT > 0) begin
                    state_nx = ST_WAITS;
                    wait_nx  = WCNT_W'(WAIT - 1);
                end else begin
                    state_nx = ST_CAPT;
                end
            end
            ST_WAITS: begin
                if (wait_cnt == '0) begin
                    state_nx = ST_CAPT;
                end else begin
                    wait_nx = wait_cnt - WCNT_W'(1);
                end
            end
            ST_CAPT: begin
                state_nx = ST_RESP;
            end
            ST_RESP: begin
                if (arb_valid) begin
                    capture  = 1'b1;
                    state_nx = ST_ISSUE;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset drops r_mem_we without a clock.
    always_ff @(posedge w_clk or negedge w_rst) begin
        if (!w_rst) begin
            state      <= ST_IDLE;
            wait_cnt   <= '0;
            owner      <= OWN_I;
            r_i_gnt    <= 1'b0;
            r_d_gnt    <= 1'b0;
            r_i_rvalid <= 1'b0;
            r_d_rvalid <= 1'b0;
            r_rdata    <= '0;
            r_mem_addr <= '0;
            r_mem_we   <= 1'b0;
            r_mem_din  <= '0;
            r_busy     <= 1'b0;
        end else begin
            state      <= state_nx;
            wait_cnt   <= wait_nx;
            r_i_gnt    <= capture && (winner == OWN_I);
            r_d_gnt    <= capture && (winner == OWN_D);
            r_mem_we   <= capture && (winner == OWN_D) && w_d_we;
            r_i_rvalid <= (state == ST_RESP) && (owner == OWN_I);
            r_d_rvalid <= (state == ST_RESP) && (owner == OWN_D);
            r_busy     <= (state_nx != ST_IDLE);
            if (capture) begin
                owner <= winner;
                if (winner == OWN_D) begin
                    r_mem_addr <= w_d_addr;
                    r_mem_din  <= w_d_wdata;
                end else begin
                    r_mem_addr <= w_i_addr;
                end
            end
            if (state == ST_CAPT) begin
                r_rdata <= w_mem_dout;
            end
        end
    end

endmodule
